// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a fixed, parameterised wait-state count.
// Each request gets exactly one response; the memory access happens on entry to RESP.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, enter_resp;

  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        acc_write, acc_err;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens straight from IDLE, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_err = (acc_addr[1:0] != 2'b00) ||
              ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_idx = acc_addr[AW+1:2];
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
      end else if ((state == RESP) && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Storage is deliberately not reset; the reset term only blocks a commit while held.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request accept and response (legal range 0-15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  memory request from the pipeline's memory stage is present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store (memWrite), 0 = load (memRead).
REQ-008 SHALL have port req_addr  input  32  byte address (ALU result).
REQ-009 SHALL have port req_wdata  input  32  store data (rt content).
REQ-010 SHALL have port req_be  input  4  byte enables for stores; bit i enables byte i (bits 8i+7:8i).
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  requester accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a cycle with req_valid = 1 and req_ready = 1.
REQ-017 SHALL, on accept, latch req_write, req_addr, req_wdata and req_be; input changes after accept SHALL have no effect on the current transaction.
REQ-018 SHALL, on accept, go IDLE->WAIT and load a 4-bit wait counter with WAIT_CYCLES; if WAIT_CYCLES = 0, it SHALL go IDLE->RESP directly.
REQ-019 SHALL decrement the counter each cycle in WAIT and go WAIT->RESP on the cycle the counter equals 1, giving exactly WAIT_CYCLES cycles in WAIT.
REQ-020 SHALL perform the memory access on the transition into RESP: a store SHALL update only enabled bytes of word req_addr[31:2]; a load SHALL register that word into rsp_rdata.
REQ-021 SHALL flag an error when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS; on error, no storage SHALL be modified, rsp_err = 1 and rsp_rdata = 0.
REQ-022 SHALL treat a store with req_be = 4'b0000 as a legal no-op: storage unchanged, rsp_err = 0.
REQ-023 SHALL hold rsp_valid = 1 in RESP, with rsp_rdata and rsp_err stable, until rsp_ready = 1; RESP->IDLE SHALL occur on that cycle.
REQ-024 SHALL keep rsp_valid = 0 outside RESP; rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid = 0.
REQ-025 SHALL give total latency from accept edge to first rsp_valid = 1 of WAIT_CYCLES + 1 cycles.
REQ-026 SHALL NOT accept a new request in the RESP->IDLE cycle; the earliest next accept is the following cycle (req_ready goes high in IDLE).
REQ-027 SHALL NOT clear the storage array on reset; contents persist across reset.

Reset
REQ-028 SHALL, while reset = 0, force state IDLE, counter 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, asynchronously.
REQ-029 SHALL, on reset asserted in WAIT, abort the transaction; a pending store SHALL NOT be committed.
REQ-030 SHALL, on reset asserted in RESP, drop the response; a store already committed on entry to RESP SHALL remain committed.

Verification
REQ-031 SHALL pass: store addr 0x10, data 0xDEADBEEF, be 4'hF, then load 0x10 -> load response rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 3 cycles after accept (WAIT_CYCLES = 2).
REQ-032 SHALL pass: after REQ-031, store addr 0x10, data 0x000000AA, be 4'b0001, then load -> rsp_rdata = 0xDEADBEAA.
REQ-033 SHALL pass: load addr 0x12, and store addr 0x400 with DEPTH_WORDS = 256 -> rsp_err = 1, rsp_rdata = 0, storage unchanged.
REQ-034 SHALL pass: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout; release -> IDLE next cycle.
REQ-035 SHALL pass: store to 0x20 (0x12345678), assert reset in WAIT, release, load 0x20 -> old contents returned, not 0x12345678; outputs at reset values during reset.
REQ-036 SHALL pass: WAIT_CYCLES = 0 build -> rsp_valid 1 cycle after accept; back-to-back requests accepted every 2 cycles with rsp_ready held 1.
